// File: rtl/sram_banked_dp.sv
// +--------------------------------------------------------------------------+
// | Module      : sram_banked_dp                                             |
// | Description : Multi-bank SRAM shared by two requesters. Words are        |
// |               interleaved across single-port banks by their low address  |
// |               bits. Round-robin arbitration on bank conflicts.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_banked_dp #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048,
  parameter int NUM_BANKS  = 4,
  parameter int OUT_REG    = 0,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  output logic                  a_gnt,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [BE_WIDTH-1:0]   a_be,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  output logic                  b_gnt,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [BE_WIDTH-1:0]   b_be,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int c_bank_bits = $clog2(NUM_BANKS);
  localparam int c_row_width = ADDR_WIDTH - c_bank_bits;
  localparam int c_rows      = DEPTH / NUM_BANKS;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                   w_req;
  logic [1:0]                   w_we;
  logic [1:0]                   w_gnt;
  logic [1:0]                   w_rvalid;
  logic [c_bank_bits-1:0]       w_bank   [2];
  logic [c_row_width-1:0]       w_row    [2];
  logic [BE_WIDTH-1:0]          w_be     [2];
  logic [DATA_WIDTH-1:0]        w_wdata  [2];
  logic [DATA_WIDTH-1:0]        w_rdata  [2];
  logic [DATA_WIDTH-1:0]        w_bank_q [NUM_BANKS];
  logic                         w_conflict;
  logic                         r_rr_ptr;

  assign w_req      = {b_req, a_req};
  assign w_we       = {b_we, a_we};
  assign w_bank[0]  = a_addr[c_bank_bits-1:0];
  assign w_bank[1]  = b_addr[c_bank_bits-1:0];
  assign w_row[0]   = a_addr[ADDR_WIDTH-1:c_bank_bits];
  assign w_row[1]   = b_addr[ADDR_WIDTH-1:c_bank_bits];
  assign w_be[0]    = a_be;
  assign w_be[1]    = b_be;
  assign w_wdata[0] = a_wdata;
  assign w_wdata[1] = b_wdata;

  // r_rr_ptr = 0 favours A, 1 favours B; only consulted on a same-bank clash.
  assign w_conflict = w_req[0] && w_req[1] && (w_bank[0] == w_bank[1]);
  assign w_gnt[0]   = w_req[0] && (!w_conflict || !r_rr_ptr);
  assign w_gnt[1]   = w_req[1] && (!w_conflict ||  r_rr_ptr);
  assign a_gnt      = w_gnt[0];
  assign b_gnt      = w_gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_conflict) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [c_rows];
    logic [DATA_WIDTH-1:0] r_q;
    logic [1:0]            w_hit;
    logic                  w_port;

    assign w_hit[0] = w_gnt[0] && (w_bank[0] == c_bank_bits'(k));
    assign w_hit[1] = w_gnt[1] && (w_bank[1] == c_bank_bits'(k));
    // Arbitration guarantees at most one hit, so the owner is simply hit[1].
    assign w_port   = w_hit[1];

    always_ff @(posedge clk) begin
      if (|w_hit) begin
        if (w_we[w_port]) begin
          for (int i = 0; i < BE_WIDTH; i++) begin
            if (w_be[w_port][i]) begin
              r_mem[w_row[w_port]][i*8 +: 8] <= w_wdata[w_port][i*8 +: 8];
            end
          end
        end else begin
          r_q <= r_mem[w_row[w_port]];
        end
      end
    end

    assign w_bank_q[k] = r_q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                   r_v1;
    logic [c_bank_bits-1:0] r_bank1;
    logic [DATA_WIDTH-1:0]  w_q;
    logic                   w_rd;

    assign w_rd = w_gnt[p] && !w_we[p];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v1    <= 1'b0;
        r_bank1 <= '0;
      end else begin
        r_v1 <= w_rd;
        if (w_rd) begin
          r_bank1 <= w_bank[p];
        end
      end
    end

    assign w_q = w_bank_q[r_bank1];

    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= w_q;
          end
        end
      end

      assign w_rvalid[p] = r_v2;
      assign w_rdata[p]  = r_d2;
    end else begin : g_out_direct
      // Bank read registers are not reset, so a held copy supplies idle/reset data.
      logic [DATA_WIDTH-1:0] r_hold;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold <= '0;
        end else if (r_v1) begin
          r_hold <= w_q;
        end
      end

      assign w_rvalid[p] = r_v1;
      assign w_rdata[p]  = r_v1 ? w_q : r_hold;
    end
  end

  assign a_rvalid = w_rvalid[0];
  assign b_rvalid = w_rvalid[1];
  assign a_rdata  = w_rdata[0];
  assign b_rdata  = w_rdata[1];

endmodule

`default_nettype wire

// File: tb/tb_sram_banked_dp.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_banked_dp                                          |
// | Description : Directed bench for sram_banked_dp, OUT_REG=0 and 1 copies, |
// |               with a read scoreboard checking data and latency.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sram_banked_dp;

  localparam int c_dw = 128;
  localparam int c_aw = 11;
  localparam int c_bw = 16;

  typedef struct {
    logic [c_dw-1:0] data;
    int              due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            a_req = 0, a_we = 0, b_req = 0, b_we = 0, p_req = 0, p_we = 0;
  logic [c_aw-1:0] a_addr = '0, b_addr = '0, p_addr = '0;
  logic [c_bw-1:0] a_be = '0, b_be = '0, p_be = '0;
  logic [c_dw-1:0] a_wdata = '0, b_wdata = '0, p_wdata = '0;
  logic            a_gnt, b_gnt, a_rvalid, b_rvalid, p_gnt, p_rvalid;
  logic [c_dw-1:0] a_rdata, b_rdata, p_rdata;
  logic            q_req = 0, q_we = 0;
  logic [c_aw-1:0] q_addr = '0;
  logic [c_bw-1:0] q_be = '0;
  logic [c_dw-1:0] q_wdata = '0;
  logic            q_gnt, q_rvalid;
  logic [c_dw-1:0] q_rdata;

  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  logic            gnt_a, gnt_b, gnt_p;
  logic [c_dw-1:0] model0 [2048];
  logic [c_dw-1:0] model1 [2048];
  exp_t            qa[$], qb[$], qp[$];
  exp_t            e_m;

  localparam logic [c_dw-1:0] c_d2 = 128'h0123456789ABCDEF0123456789ABCDEF;

  sram_banked_dp #(.DATA_WIDTH(c_dw), .DEPTH(2048), .NUM_BANKS(4), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_gnt(a_gnt), .a_we(a_we), .a_addr(a_addr), .a_be(a_be),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_addr(b_addr), .b_be(b_be),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  sram_banked_dp #(.DATA_WIDTH(c_dw), .DEPTH(2048), .NUM_BANKS(4), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(p_req), .a_gnt(p_gnt), .a_we(p_we), .a_addr(p_addr), .a_be(p_be),
    .a_wdata(p_wdata), .a_rvalid(p_rvalid), .a_rdata(p_rdata),
    .b_req(q_req), .b_gnt(q_gnt), .b_we(q_we), .b_addr(q_addr), .b_be(q_be),
    .b_wdata(q_wdata), .b_rvalid(q_rvalid), .b_rdata(q_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [c_dw-1:0] obs, input logic [c_dw-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [c_dw-1:0] merge(input logic [c_dw-1:0] old,
                                             input logic [c_bw-1:0] be,
                                             input logic [c_dw-1:0] d);
    logic [c_dw-1:0] r = old;
    for (int i = 0; i < c_bw; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic set_a(input logic req, input logic we, input logic [c_aw-1:0] ad,
                       input logic [c_bw-1:0] be, input logic [c_dw-1:0] d);
    a_req = req; a_we = we; a_addr = ad; a_be = be; a_wdata = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [c_aw-1:0] ad,
                       input logic [c_bw-1:0] be, input logic [c_dw-1:0] d);
    b_req = req; b_we = we; b_addr = ad; b_be = be; b_wdata = d;
  endtask

  task automatic set_p(input logic req, input logic we, input logic [c_aw-1:0] ad,
                       input logic [c_bw-1:0] be, input logic [c_dw-1:0] d);
    p_req = req; p_we = we; p_addr = ad; p_be = be; p_wdata = d;
  endtask

  // Called at a negedge with inputs set; records grants, updates the model, ends at next negedge.
  task automatic step();
    #1;
    gnt_a = a_gnt; gnt_b = b_gnt; gnt_p = p_gnt;
    if (a_req && a_gnt && !a_we) qa.push_back('{model0[a_addr], cyc + 1});
    if (b_req && b_gnt && !b_we) qb.push_back('{model0[b_addr], cyc + 1});
    if (p_req && p_gnt && !p_we) qp.push_back('{model1[p_addr], cyc + 2});
    if (a_req && a_gnt && a_we) model0[a_addr] = merge(model0[a_addr], a_be, a_wdata);
    if (b_req && b_gnt && b_we) model0[b_addr] = merge(model0[b_addr], b_be, b_wdata);
    if (p_req && p_gnt && p_we) model1[p_addr] = merge(model1[p_addr], p_be, p_wdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_a(0, 0, '0, '0, '0); set_b(0, 0, '0, '0, '0); set_p(0, 0, '0, '0, '0);
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rvalid) begin
        if (qa.size() == 0) chk("a_unexpected_rvalid", a_rvalid, 0);
        else begin
          e_m = qa.pop_front();
          chk("a_rdata", a_rdata, e_m.data);
          chk("a_latency", cyc, e_m.due);
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        e_m = qa.pop_front();
        chk("a_missing_rvalid", a_rvalid, 1);
      end
      if (b_rvalid) begin
        if (qb.size() == 0) chk("b_unexpected_rvalid", b_rvalid, 0);
        else begin
          e_m = qb.pop_front();
          chk("b_rdata", b_rdata, e_m.data);
          chk("b_latency", cyc, e_m.due);
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        e_m = qb.pop_front();
        chk("b_missing_rvalid", b_rvalid, 1);
      end
      if (p_rvalid) begin
        if (qp.size() == 0) chk("p_unexpected_rvalid", p_rvalid, 0);
        else begin
          e_m = qp.pop_front();
          chk("p_rdata", p_rdata, e_m.data);
          chk("p_latency", cyc, e_m.due);
        end
      end else if (qp.size() != 0 && qp[0].due <= cyc) begin
        e_m = qp.pop_front();
        chk("p_missing_rvalid", p_rvalid, 1);
      end
      if (q_rvalid) chk("q_unexpected_rvalid", q_rvalid, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write on A, read on B next cycle, result the cycle after.
    set_a(1, 1, 11'h005, '1, c_d2);
    step();
    chk("t2_a_wr_gnt", gnt_a, 1);
    set_a(0, 0, '0, '0, '0);
    set_b(1, 0, 11'h005, '0, '0);
    step();
    chk("t2_b_rd_gnt", gnt_b, 1);
    chk("t2_b_rvalid", b_rvalid, 1);
    chk("t2_b_rdata", b_rdata, c_d2);
    idle(1);
    chk("t2_b_rvalid_low", b_rvalid, 0);
    chk("t2_b_rdata_hold", b_rdata, c_d2);

    // Byte-enable partial write.
    set_a(1, 1, 11'h010, '1, '0);
    step();
    set_a(1, 1, 11'h010, 16'h0001, '1);
    step();
    set_a(1, 0, 11'h010, '0, '0);
    step();
    chk("t3_a_rvalid", a_rvalid, 1);
    chk("t3_a_rdata", a_rdata, 128'hFF);
    idle(1);

    // Same-bank conflict and round-robin.
    set_a(1, 1, 11'h004, '1, {4{32'hA0A0_0004}});
    step();
    set_a(1, 1, 11'h008, '1, {4{32'hB0B0_0008}});
    step();
    set_a(1, 0, 11'h004, '0, '0);
    set_b(1, 0, 11'h008, '0, '0);
    step();
    chk("t4_c1_a_gnt", gnt_a, 1);
    chk("t4_c1_b_gnt", gnt_b, 0);
    set_a(0, 0, '0, '0, '0);
    step();
    chk("t4_c1_b_gnt_next", gnt_b, 1);
    set_a(1, 0, 11'h004, '0, '0);
    set_b(1, 0, 11'h008, '0, '0);
    step();
    chk("t4_c2_a_gnt", gnt_a, 0);
    chk("t4_c2_b_gnt", gnt_b, 1);
    set_b(0, 0, '0, '0, '0);
    step();
    chk("t4_c2_a_gnt_next", gnt_a, 1);
    idle(2);

    // Parallel access to different banks.
    set_a(1, 1, 11'h001, '1, {$urandom, $urandom, $urandom, $urandom});
    set_b(1, 1, 11'h002, '1, {$urandom, $urandom, $urandom, $urandom});
    step();
    chk("t5_wr_a_gnt", gnt_a, 1);
    chk("t5_wr_b_gnt", gnt_b, 1);
    set_a(1, 0, 11'h001, '0, '0);
    set_b(1, 0, 11'h002, '0, '0);
    step();
    chk("t5_rd_a_gnt", gnt_a, 1);
    chk("t5_rd_b_gnt", gnt_b, 1);
    chk("t5_a_rvalid", a_rvalid, 1);
    chk("t5_b_rvalid", b_rvalid, 1);
    idle(2);

    // OUT_REG=1 copy: back-to-back reads 0..7.
    for (int i = 0; i < 8; i++) begin
      set_p(1, 1, 11'(i), '1, {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    for (int i = 0; i < 8; i++) begin
      set_p(1, 0, 11'(i), '0, '0);
      step();
      chk("t6_p_gnt", gnt_p, 1);
      chk("t6_p_rvalid", p_rvalid, (i >= 1) ? 1'b1 : 1'b0);
    end
    idle(1);
    chk("t6_p_rvalid_last", p_rvalid, 1);
    idle(1);
    chk("t6_p_rvalid_end", p_rvalid, 0);
    idle(1);

    // Reset mid-stream with reads in flight; the conflict also moves rr_ptr to B.
    set_a(1, 0, 11'h005, '0, '0);
    set_b(1, 0, 11'h001, '0, '0);
    set_p(1, 0, 11'h003, '0, '0);
    #1;
    chk("t1_conf_a_gnt", a_gnt, 1);
    chk("t1_conf_b_gnt", b_gnt, 0);
    @(posedge clk);
    #2;
    chk("t1_inflight_a", a_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_a_rvalid", a_rvalid, 0);
    chk("t1_a_rdata", a_rdata, 0);
    chk("t1_b_rvalid", b_rvalid, 0);
    chk("t1_b_rdata", b_rdata, 0);
    chk("t1_p_rvalid", p_rvalid, 0);
    chk("t1_p_rdata", p_rdata, 0);
    set_a(0, 0, '0, '0, '0); set_b(0, 0, '0, '0, '0); set_p(0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    set_a(1, 0, 11'h005, '0, '0);
    set_b(1, 0, 11'h001, '0, '0);
    step();
    chk("t1_post_rst_a_gnt", gnt_a, 1);
    chk("t1_post_rst_b_gnt", gnt_b, 0);
    set_a(0, 0, '0, '0, '0);
    step();
    chk("t1_post_rst_b_gnt_next", gnt_b, 1);
    idle(4);

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_p", qp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
